// File: rtl/alu_ctrl_seq_pkg.sv
// Shared constants for the accumulator-ALU instruction sequencer:
// ALU operation codes, instruction opcodes and FSM state encodings.
package alu_ctrl_seq_pkg;

    // ALU operation codes seen on alu_op
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd2;
    localparam logic [2:0] ALU_DIV  = 3'd3;
    localparam logic [2:0] ALU_MOD  = 3'd4;

    // Instruction opcodes (instr[11:8]); 10..15 are illegal
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_MULI = 4'd3;
    localparam logic [3:0] OP_DIVI = 4'd4;
    localparam logic [3:0] OP_MODI = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_LDM  = 4'd8;
    localparam logic [3:0] OP_ADDM = 4'd9;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEM_REQ = 2'd1,
        S_EXEC    = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: opcode/imm to ALU op, strobe
// selects and the memory / illegal / divide-by-zero classification.
module alu_ctrl_decode
    import alu_ctrl_seq_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [7:0] imm_i,
    output logic [2:0] alu_op_o,
    output logic       wen_o,
    output logic       inc_o,
    output logic       clr_o,
    output logic       is_mem_o,
    output logic       illegal_o,
    output logic       div0_o
);

    // Opcode table; at most one strobe select is ever set
    always_comb begin
        alu_op_o  = ALU_NONE;
        wen_o     = 1'b0;
        inc_o     = 1'b0;
        clr_o     = 1'b0;
        is_mem_o  = 1'b0;
        illegal_o = 1'b0;
        div0_o    = 1'b0;
        case (opcode_i)
            OP_NOP:  ;
            OP_LDI:  wen_o = 1'b1;
            OP_ADDI: alu_op_o = ALU_ADD;
            OP_MULI: alu_op_o = ALU_MUL;
            OP_DIVI: begin
                alu_op_o = ALU_DIV;
                div0_o   = (imm_i == 8'd0);
            end
            OP_MODI: begin
                alu_op_o = ALU_MOD;
                div0_o   = (imm_i == 8'd0);
            end
            OP_INC:  inc_o = 1'b1;
            OP_CLR:  clr_o = 1'b1;
            OP_LDM: begin
                wen_o    = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_ADDM: begin
                alu_op_o = ALU_ADD;
                is_mem_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Instruction sequencer feeding the 8-bit accumulator ALU. Accepts one
// instruction at a time, optionally fetches a memory operand, and issues
// a single-cycle registered control/operand word per executed instruction.
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [11:0] instr,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  alu_op,
    output logic        Wen,
    output logic        INC,
    output logic        acc_clr,
    output logic [7:0]  BusOut,
    output logic        done,
    input  logic        err_clr,
    output logic        err_illegal,
    output logic        err_div0,
    output logic        err_timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    // Counter value during the last permitted MEM_REQ cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             wen_q, wen_d, inc_q, inc_d, clr_q, clr_d;
    logic             done_q, done_d;
    logic [7:0]       bus_q, bus_d;
    logic             mem_req_q, mem_req_d;
    logic [7:0]       mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_op_q, pend_op_d;
    logic             pend_wen_q, pend_wen_d;
    logic [2:0]       err_q, err_d;        // {timeout, div0, illegal}
    logic [2:0]       err_new;

    logic [2:0] dec_alu_op;
    logic       dec_wen, dec_inc, dec_clr, dec_is_mem, dec_illegal, dec_div0;

    alu_ctrl_decode u_decode (
        .opcode_i  (instr[11:8]),
        .imm_i     (instr[7:0]),
        .alu_op_o  (dec_alu_op),
        .wen_o     (dec_wen),
        .inc_o     (dec_inc),
        .clr_o     (dec_clr),
        .is_mem_o  (dec_is_mem),
        .illegal_o (dec_illegal),
        .div0_o    (dec_div0)
    );

    assign instr_ready = (state_q == S_IDLE) && !RST;

    // Next-state, next-output and error-detection logic
    always_comb begin
        state_d    = state_q;
        alu_op_d   = ALU_NONE;
        wen_d      = 1'b0;
        inc_d      = 1'b0;
        clr_d      = 1'b0;
        done_d     = 1'b0;
        bus_d      = bus_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        cnt_d      = '0;
        pend_op_d  = pend_op_q;
        pend_wen_d = pend_wen_q;
        err_new    = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    if (dec_illegal) begin
                        err_new[0] = 1'b1;
                    end else if (dec_div0) begin
                        err_new[1] = 1'b1;
                    end else if (dec_is_mem) begin
                        state_d    = S_MEM_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = instr[7:0];
                        pend_op_d  = dec_alu_op;
                        pend_wen_d = dec_wen;
                    end else begin
                        state_d  = S_EXEC;
                        alu_op_d = dec_alu_op;
                        wen_d    = dec_wen;
                        inc_d    = dec_inc;
                        clr_d    = dec_clr;
                        bus_d    = instr[7:0];
                        done_d   = 1'b1;
                    end
                end
            end
            S_MEM_REQ: begin
                // An ack in the final permitted cycle takes priority over the timeout
                if (mem_ack) begin
                    state_d  = S_EXEC;
                    alu_op_d = pend_op_q;
                    wen_d    = pend_wen_q;
                    bus_d    = mem_rdata;
                    done_d   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_IDLE;
                    err_new[2] = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A fresh error wins over a simultaneous clear
        err_d = (err_q & {3{~err_clr}}) | err_new;
    end

    // Registered state and outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q    <= S_IDLE;
            alu_op_q   <= ALU_NONE;
            wen_q      <= 1'b0;
            inc_q      <= 1'b0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
            bus_q      <= 8'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 8'd0;
            cnt_q      <= '0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            alu_op_q   <= alu_op_d;
            wen_q      <= wen_d;
            inc_q      <= inc_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
            bus_q      <= bus_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Pending memory-op controls; only meaningful while in MEM_REQ
    always_ff @(posedge Clk) begin
        pend_op_q  <= pend_op_d;
        pend_wen_q <= pend_wen_d;
    end

    assign alu_op      = alu_op_q;
    assign Wen         = wen_q;
    assign INC         = inc_q;
    assign acc_clr     = clr_q;
    assign done        = done_q;
    assign BusOut      = bus_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign err_illegal = err_q[0];
    assign err_div0    = err_q[1];
    assign err_timeout = err_q[2];

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Instruction sequencer directly upstream of the 8-bit accumulator ALU. It accepts 12-bit instruction words over a valid/ready handshake and fetches memory operands through a req/ack port when needed. For each instruction it drives the ALU control strobes (`alu_op`, `Wen`, `INC`, `acc_clr`) together with the 8-bit operand bus (`BusOut`) for exactly one cycle. It also guards against divide/modulo by zero, illegal opcodes and memory stalls.

## Interface
- `MEM_TIMEOUT`, default 15: number of `MEM_REQ` cycles without `mem_ack` before the request is aborted.
- `Clk` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `instr_valid` in 1: instruction word present.
- `instr_ready` out 1: sequencer can accept an instruction.
- `instr` in 12: opcode in [11:8], immediate/address in [7:0].
- `mem_req` out 1: memory read request.
- `mem_addr` out 8: read address.
- `mem_ack` in 1: `mem_rdata` is valid this cycle.
- `mem_rdata` in 8: memory read data.
- `alu_op` out 3: ALU operation code.
- `Wen` out 1: accumulator load strobe.
- `INC` out 1: accumulator increment strobe.
- `acc_clr` out 1: accumulator clear strobe, connected to the ALU's clear input.
- `BusOut` out 8: operand bus to the ALU.
- `done` out 1: one-cycle pulse when an instruction executes.
- `err_clr` in 1: clears the sticky error flags.
- `err_illegal`, `err_div0`, `err_timeout` out 1 each: sticky error flags.

## Operation
- ALU op codes: NONE=0, ADD=1, MUL=2, DIV=3, MOD=4.
- Opcodes and their ALU effect:
  - NOP=0: `alu_op` NONE, no strobe.
  - LDI=1: NONE with `Wen`, `BusOut`=imm.
  - ADDI=2: ADD, imm.
  - MULI=3: MUL, imm.
  - DIVI=4: DIV, imm.
  - MODI=5: MOD, imm.
  - INC=6: NONE with `INC`.
  - CLR=7: NONE with `acc_clr`.
  - LDM=8: read memory at imm, then NONE with `Wen`, `BusOut`=`mem_rdata`.
  - ADDM=9: read memory at imm, then ADD, `BusOut`=`mem_rdata`.
  - 10..15: illegal.
- FSM states are `IDLE`, `MEM_REQ` and `EXEC`.
- `IDLE`:
  - `instr_ready`=1. Accept on `instr_valid`&`instr_ready`.
  - Illegal opcode: set `err_illegal`, stay in `IDLE`, no strobe, no `done`.
  - DIVI/MODI with imm=0: set `err_div0`, stay in `IDLE`, no strobe, no `done`.
  - LDM/ADDM: go to `MEM_REQ`.
  - All other opcodes: latch the controls and go to `EXEC`.
- `MEM_REQ`:
  - `mem_req`=1 and `mem_addr`=imm, held stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata` into `BusOut`, go to `EXEC`.
  - Timeout counter increments each cycle spent here. When it reaches `MEM_TIMEOUT` without ack: set `err_timeout`, drop `mem_req`, return to `IDLE`, no strobe, no `done`.
  - Ack arriving in the same cycle the limit is reached: the ack wins.
- `EXEC`: strobes and `alu_op` are valid for exactly one cycle, `done`=1, then return to `IDLE`.
- Outside `EXEC`: `alu_op`=NONE, `Wen`=`INC`=`acc_clr`=0. `BusOut` holds its last value.
- At most one of `Wen`/`INC`/`acc_clr` is ever high.
- Error flags are sticky and cleared by `RST` or `err_clr`. A new error in the same cycle as `err_clr` leaves the flag set.
- The accumulator is not cleared by `RST` of this block; only the CLR opcode clears it.

## Timing
- All outputs are registered, except `instr_ready`, which is (state==`IDLE`) && !`RST`.
- Reset values: state `IDLE`; `alu_op`=0; `Wen`=`INC`=`acc_clr`=`mem_req`=`done`=0; `BusOut`=`mem_addr`=0; all error flags 0; timeout counter 0.
- `instr_ready`=1 in the first cycle after `RST` deasserts.
- Immediate-operand ops:
  - Accept at edge T; `EXEC` occupies cycle T+1, so strobes and `done` are high during T+1.
  - The ALU's `dout` updates at the end of T+1.
  - `instr_ready` returns high in T+2. Throughput is 1 instruction per 2 cycles.
- Memory ops:
  - `mem_req` high from T+1.
  - `mem_ack` sampled in cycle A leads to `EXEC` in A+1, so latency is 2 + memory wait.
- Error rejections: `instr_ready` stays high, so the next instruction is accepted in T+1. The flag is visible from T+1.
- `RST` mid-operation: at the next edge the FSM is in `IDLE` and `mem_req` plus all strobes are 0. An `EXEC` interrupted by `RST` still asserts its strobes during its cycle, because the outputs are already registered.

## Structure
- Shared define header holds:
  - ALU op codes.
  - Opcode constants `OP_NOP`..`OP_ADDM`.
  - State encodings `S_IDLE`, `S_MEM_REQ`, `S_EXEC`.
- One combinational sub-module, `alu_ctrl_decode`: maps opcode and imm to `alu_op`, strobe selects, the is-memory flag, the illegal flag and the div0 flag.
- The sequencer instantiates `alu_ctrl_decode` and owns the FSM, the timeout counter and the error registers.

## Test plan
- Sequence LDI 0x05, ADDI 0x03, MULI 0x04, MODI 0x07 with back-to-back `instr_valid`:
  - `done` pulses every 2 cycles.
  - Each `EXEC` cycle shows `alu_op` 0/1/2/4 and `BusOut` 05/03/04/07.
  - ALU `dout` ends at 0x04.
- DIVI 0x00, then opcode 0xC:
  - `err_div0`, then `err_illegal`, set; no strobes, no `done`; `instr_ready` stays 1.
  - `err_clr` clears both flags.
- ADDM 0x10 with the memory acking 0x22 after 3 cycles:
  - `mem_addr`=0x10 held stable.
  - `EXEC` one cycle after the ack, with `alu_op`=1 and `BusOut`=0x22.
- LDM with no ack:
  - `mem_req` drops after 15 cycles and `err_timeout`=1.
  - Ack on exactly the 15th cycle: executes normally with no error.
- INC, then CLR: `INC` and `acc_clr` each high for exactly one cycle, never together.
- `RST` asserted during `MEM_REQ`: next cycle `mem_req`=0, state `IDLE`, flags 0; the instruction is dropped and `done` never pulses.
